// File: rtl/jtdsp16_rom_loader.sv
// Streams firmware bytes into the DSP16 program ROM, holding the DSP in
// reset until every byte has been written and a short settling time has
// elapsed. A running 16-bit byte sum is kept for host-side verification.
module jtdsp16_rom_loader #(
  parameter int LEN  = 8192,
  parameter int HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_start,
  input  logic        dl_abort,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        dsp_rst,
  output logic        busy,
  output logic        done,
  output logic [15:0] csum
);

  localparam logic [12:0] LAST   = 13'(LEN - 1);
  localparam logic [3:0]  HOLD_N = 4'(HOLD);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic        xfer;
  logic        start_load;
  logic [12:0] counter;
  logic [3:0]  hold_cnt;

  // Only the handshake is combinational; everything else is registered.
  assign dl_ready   = (state == LOAD);
  assign start_load = (next_state == LOAD) && (state != LOAD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort always wins and a transfer with abort is dropped.
  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!dl_abort && dl_start) next_state = LOAD;
      end
      LOAD: begin
        if (dl_abort) begin
          next_state = IDLE;
        end else if (dl_valid) begin
          xfer = 1'b1;
          if (counter == LAST) next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (dl_abort)                next_state = IDLE;
        else if (hold_cnt == HOLD_N) next_state = DONE;
      end
      DONE: begin
        if (dl_abort)      next_state = IDLE;
        else if (dl_start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write port, byte counter and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_we   <= 1'b0;
      prog_addr <= 13'd0;
      prog_data <= 8'd0;
      counter   <= 13'd0;
      csum      <= 16'd0;
    end else begin
      prog_we <= xfer;
      if (start_load) begin
        counter <= 13'd0;
        csum    <= 16'd0;
      end else if (xfer) begin
        prog_addr <= counter;
        prog_data <= dl_data;
        counter   <= counter + 13'd1;
        csum      <= csum + {8'd0, dl_data};
      end
    end
  end

  // Settling counter: FLUSH lasts HOLD+1 cycles, the first being the
  // cycle of the final write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 4'd0;
    end else if (state != FLUSH) begin
      hold_cnt <= 4'd0;
    end else begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  // Status flags follow the state being entered; the DSP leaves reset only
  // on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      dsp_rst <= (next_state != DONE);
      busy    <= (next_state == LOAD) || (next_state == FLUSH);
      done    <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Bench for jtdsp16_rom_loader: a small LEN=8 instance for protocol
// scenarios and a full-size instance for the 8192-byte download.
module tb_jtdsp16_rom_loader;

  localparam int LEN    = 8;
  localparam int HOLD   = 4;
  localparam int LEN_B  = 8192;
  localparam int HOLD_B = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dl_start = 0, dl_abort = 0, dl_valid = 0;
  logic [7:0]  dl_data = 0;
  logic        dl_ready, prog_we, dsp_rst, busy, done;
  logic [12:0] prog_addr;
  logic [7:0]  prog_data;
  logic [15:0] csum;

  logic        b_dl_start = 0, b_dl_abort = 0, b_dl_valid = 0;
  logic [7:0]  b_dl_data = 0;
  logic        b_dl_ready, b_prog_we, b_dsp_rst, b_busy, b_done;
  logic [12:0] b_prog_addr;
  logic [7:0]  b_prog_data;
  logic [15:0] b_csum;

  jtdsp16_rom_loader #(.LEN(LEN), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .dl_start(dl_start), .dl_abort(dl_abort),
    .dl_valid(dl_valid), .dl_data(dl_data), .dl_ready(dl_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .dsp_rst(dsp_rst), .busy(busy), .done(done), .csum(csum)
  );

  jtdsp16_rom_loader #(.LEN(LEN_B), .HOLD(HOLD_B)) dut_big (
    .clk(clk), .rst_n(rst_n), .dl_start(b_dl_start), .dl_abort(b_dl_abort),
    .dl_valid(b_dl_valid), .dl_data(b_dl_data), .dl_ready(b_dl_ready),
    .prog_addr(b_prog_addr), .prog_data(b_prog_data), .prog_we(b_prog_we),
    .dsp_rst(b_dsp_rst), .busy(b_busy), .done(b_done), .csum(b_csum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [12:0] addr; logic [7:0] data; int c; } wr_t;
  typedef struct { logic [12:0] addr; logic [7:0] data; } ex_t;
  wr_t got_q[$];
  ex_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bytes accepted while a download is open, in order.
  bit        m_active = 0;
  bit        m_flush  = 0;
  int        m_count  = 0;
  logic [15:0] m_sum  = 0;

  int b_wcount = 0;
  int b_seq_err = 0;
  logic [12:0] b_last = 0;

  // Write monitors.
  always @(negedge clk) begin
    if (prog_we === 1'b1) got_q.push_back('{prog_addr, prog_data, cyc});
    if (b_prog_we === 1'b1) begin
      if (b_prog_addr !== 13'(b_wcount)) b_seq_err++;
      b_last = b_prog_addr;
      b_wcount++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit a);
    @(negedge clk);
    chk("dl_ready", {31'd0, dl_ready}, {31'd0, m_active});
    chk("rst_vs_done", {31'd0, dsp_rst}, {31'd0, ~done});
    dl_valid = v; dl_data = d; dl_start = s; dl_abort = a;
    if (a) begin
      m_active = 0; m_flush = 0;
    end else if (m_active) begin
      if (v) begin
        exp_q.push_back('{13'(m_count), d});
        m_sum = m_sum + 16'(d);
        m_count++;
        if (m_count == LEN) begin m_active = 0; m_flush = 1; end
      end
    end else if (s && !m_flush) begin
      m_active = 1; m_count = 0; m_sum = 0;
    end
  endtask

  task automatic wait_done(input string tag);
    int done_cyc;
    int last_c;
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 8'h00, 0, 0);
      if (done === 1'b1) begin done_cyc = cyc; break; end
    end
    last_c = (got_q.size() > 0) ? got_q[got_q.size()-1].c : -100;
    chk({tag, "_done_timing"}, done_cyc, last_c + HOLD + 1);
    chk({tag, "_dsp_rst"}, {31'd0, dsp_rst}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_csum"}, {16'd0, csum}, {16'd0, m_sum});
    m_flush = 0;
  endtask

  task automatic cmp_writes(input string tag, input bit consec);
    int n;
    chk({tag, "_wcount"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, {19'd0, got_q[i].addr}, {19'd0, exp_q[i].addr});
      chk({tag, "_data"}, {24'd0, got_q[i].data}, {24'd0, exp_q[i].data});
      if (consec && i > 0) chk({tag, "_consec"}, got_q[i].c, got_q[i-1].c + 1);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int guard;
    int b_done_seen;

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    chk("rst_dsp_rst", {31'd0, dsp_rst}, 32'd1);
    chk("rst_prog_we", {31'd0, prog_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_csum", {16'd0, csum}, 32'd0);
    chk("rst_addr", {19'd0, prog_addr}, 32'd0);
    chk("rst_dl_ready", {31'd0, dl_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Eight bytes 01..08 back to back
    step(0, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 1) chk("busy_load", {31'd0, busy}, 32'd1);
    end
    wait_done("seq");
    chk("csum_seq_const", {16'd0, csum}, 32'h0024);
    chk("done_seq", {31'd0, done}, 32'd1);
    cmp_writes("seq", 1);

    // Restart from DONE, valid toggling, start during LOAD and FLUSH ignored
    step(0, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(8'h10 + i), (i == 3), 0);
      step(0, 8'hEE, 0, 0);
    end
    step(1, 8'hA1, 0, 0);
    step(1, 8'h99, 1, 0);
    step(1, 8'hA2, 0, 0);
    wait_done("toggle");
    cmp_writes("toggle", 0);

    // Randomized downloads
    for (int r = 0; r < 3; r++) begin
      step(0, 8'h00, 1, 0);
      guard = 0;
      while (m_active && guard < 300) begin
        step(1'($urandom_range(0, 1)), 8'($urandom), 0, 0);
        guard++;
      end
      wait_done("rand");
      cmp_writes("rand", 0);
    end

    // Abort together with start in DONE: abort wins
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 0);
    chk("abort_done_done", {31'd0, done}, 32'd0);
    chk("abort_done_rst", {31'd0, dsp_rst}, 32'd1);

    // Abort coinciding with the third transfer
    step(0, 8'h00, 1, 0);
    step(1, 8'h5A, 0, 0);
    step(1, 8'hC3, 0, 0);
    step(1, 8'h77, 0, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dsp_rst", {31'd0, dsp_rst}, 32'd1);
    cmp_writes("abort", 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("restart_csum", {16'd0, csum}, 32'd0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0);
    wait_done("restart");
    cmp_writes("restart", 1);

    // Asynchronous reset mid-LOAD
    step(0, 8'h00, 1, 0);
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    @(negedge clk);
    dl_valid = 1'b1; dl_data = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_prog_we", {31'd0, prog_we}, 32'd0);
    chk("arst_dsp_rst", {31'd0, dsp_rst}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_csum", {16'd0, csum}, 32'd0);
    chk("arst_addr", {19'd0, prog_addr}, 32'd0);
    chk("arst_data", {24'd0, prog_data}, 32'd0);
    chk("arst_dl_ready", {31'd0, dl_ready}, 32'd0);
    m_active = 0; m_flush = 0; m_sum = 0; m_count = 0;
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 0);
    step(0, 8'h00, 0, 0);
    cmp_writes("arst", 1);

    // Full-size download of 0xFF bytes
    @(negedge clk) b_dl_start = 1'b1;
    @(negedge clk) begin
      b_dl_start = 1'b0; b_dl_valid = 1'b1; b_dl_data = 8'hFF;
    end
    repeat (LEN_B + 5) @(negedge clk);
    chk("big_dl_ready", {31'd0, b_dl_ready}, 32'd0);
    b_dl_valid = 1'b0;
    b_done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (b_done === 1'b1) begin b_done_seen = 1; break; end
      @(negedge clk);
    end
    chk("big_done", b_done_seen, 1);
    chk("big_wcount", b_wcount, LEN_B);
    chk("big_last_addr", {19'd0, b_last}, 32'h1FFF);
    chk("big_seq", b_seq_err, 0);
    chk("big_csum", {16'd0, b_csum}, (LEN_B * 255) % 65536);
    chk("big_dsp_rst", {31'd0, b_dsp_rst}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdsp16_rom_loader.md
JTDSP16_ROM_LOADER -- requirements
Module: jtdsp16_rom_loader

Interface
REQ-001 SHALL have parameter LEN, default 8192, meaning number of firmware bytes per download (legal 2..8192, even).
REQ-002 SHALL have parameter HOLD, default 4, meaning cycles of extra DSP reset after the last ROM write (legal 2..15).
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: dl_start  in  1  one-cycle request to begin a download.
REQ-006 SHALL have ports: dl_abort  in  1  cancel an active download.
REQ-007 SHALL have ports: dl_valid  in  1  byte-stream valid; dl_data  in  8  byte, LSB of each ROM word first.
REQ-008 SHALL have ports: dl_ready  out  1  loader accepts dl_data this cycle.
REQ-009 SHALL have ports: prog_addr  out  13  byte address; bit 0 = 0 selects LSB, 1 selects MSB of ROM word prog_addr[12:1].
REQ-010 SHALL have ports: prog_data  out  8  byte to write; prog_we  out  1  one-cycle write strobe.
REQ-011 SHALL have ports: dsp_rst  out  1  active-high DSP reset, held while the ROM is programmed.
REQ-012 SHALL have ports: busy  out  1; done  out  1; csum  out  16  running byte sum of the current download.

Function
REQ-013 SHALL implement states IDLE, LOAD, FLUSH, DONE; all outputs registered except dl_ready, which equals (state==LOAD).
REQ-014 IDLE: dl_start=1 -> LOAD next cycle; byte counter, csum cleared to 0; done=0; busy=1; dsp_rst=1.
REQ-015 LOAD: transfer occurs when dl_valid & dl_ready at a rising edge; dl_valid while dl_ready=0 SHALL be ignored, no data lost or duplicated.
REQ-016 Per transfer, next cycle: prog_we=1 for exactly one cycle, prog_addr=counter value at transfer, prog_data=dl_data; counter+1; csum+=dl_data, mod 2^16.
REQ-017 prog_addr and prog_data SHALL hold their last values while prog_we=0; back-to-back transfers SHALL yield prog_we high on consecutive cycles with consecutive addresses.
REQ-018 Transfer of byte index LEN-1 SHALL move to FLUSH the same edge; dl_ready=0 the following cycle; no byte index >= LEN is ever written.
REQ-019 FLUSH: dsp_rst=1 for HOLD cycles counted from the cycle after the last prog_we pulse, then DONE.
REQ-020 DONE: dsp_rst=0, done=1, busy=0, csum frozen; dl_start=1 -> LOAD with the same clearing as REQ-014.
REQ-021 dl_start in LOAD or FLUSH SHALL be ignored.
REQ-022 dl_abort in LOAD or FLUSH -> IDLE next cycle; a transfer coinciding with abort SHALL be dropped (no prog_we); dsp_rst stays 1, done=0, busy=0.
REQ-023 dl_abort and dl_start together in IDLE or DONE: abort wins, state -> IDLE.
REQ-024 dsp_rst SHALL only fall when entering DONE, so the DSP never runs on a partially written ROM.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, dsp_rst=1, prog_we=0, prog_addr=0, prog_data=0, done=0, busy=0, csum=0, counter=0.
REQ-026 Reset asserted mid-LOAD SHALL discard the download; no prog_we pulse after rst_n falls; restart requires dl_start.

Verification
REQ-027 LEN=8: dl_start, then 8 bytes 01..08 with dl_valid held high -> prog_we on 8 consecutive cycles, addr 0..7, data 01..08; csum=0x0024; done=1 and dsp_rst=0 HOLD+1 cycles after last prog_we.
REQ-028 LEN=8, dl_valid toggled 1/0 -> same writes as REQ-027, spaced, no duplicates; dl_valid kept high after byte 8 -> dl_ready=0, no extra prog_we.
REQ-029 LEN=8192, all bytes 0xFF -> last write addr 0x1FFF, csum=(8192*255) mod 65536=0xE000.
REQ-030 dl_abort coincident with 3rd transfer -> only addr 0,1 written; state IDLE; dsp_rst=1; done=0; new dl_start restarts at addr 0 with csum=0.
REQ-031 rst_n pulsed low mid-LOAD (asynchronously between edges) -> outputs at reset values immediately; dl_start during LOAD and in DONE -> ignored and restart respectively.
